// File: rtl/median_result_writer_if.sv
// rtl/median_result_writer_if.sv - handshake bundle between the control unit, the writer and frame memory
//
// Purpose: groups the done/pixIn capture strobe and the wrEn/wrReady write
// handshake of the median result writer into one port.
// master: the writer block (samples done/pixIn/wrReady, drives the rest).
// slave : the environment (control unit + frame memory).
//   done      - one-cycle strobe, pixIn holds a valid median
//   pixIn     - median pixel
//   wrEn      - write request to frame memory
//   wrAddr    - raster write address
//   wrData    - pixel being written
//   wrReady   - memory accepts the write this cycle
//   frameDone - one-cycle pulse after the last pixel of a frame
//   overflow  - sticky pixel-dropped flag
//   busy      - FIFO non-empty or frame partially written
interface median_result_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
);
  logic              done;
  logic [DATA_W-1:0] pixIn;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              wrReady;
  logic              frameDone;
  logic              overflow;
  logic              busy;

  modport master (
    input  done, pixIn, wrReady,
    output wrEn, wrAddr, wrData, frameDone, overflow, busy
  );

  modport slave (
    output done, pixIn, wrReady,
    input  wrEn, wrAddr, wrData, frameDone, overflow, busy
  );
endinterface

// File: rtl/median_result_writer.sv
// rtl/median_result_writer.sv - median filter write-back stage: pixel FIFO plus raster frame writer
//
// Purpose: captures one median pixel per done strobe into a DEPTH-entry FIFO
// and streams the pixels to frame memory at row*LENGTH+col addresses.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - median_result_writer_if.master (done/pixIn in, write handshake out,
//         frameDone/overflow/busy status)
module median_result_writer #(
  parameter int LENGTH = 640,
  parameter int WIDTH  = 480,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 19
) (
  input  logic                   clk,
  input  logic                   rst,
  median_result_writer_if.master bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int COL_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int ROW_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    FRAME_END = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              overflow_q;
  logic              busy_q, busy_d;
  logic              push, pop, last_col, last_row;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign pop      = (state_q == WRITE) && bus.wrReady;
  assign push     = bus.done && ((count_q < CNT_W'(DEPTH)) || pop);
  assign last_col = (col_q == COL_W'(LENGTH - 1));
  assign last_row = (row_q == ROW_W'(WIDTH - 1));

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Raster position: address advances by one per transfer instead of row*LENGTH+col.
  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    addr_d = addr_q;
    if (pop) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d  = '0;
          addr_d = '0;
        end else begin
          row_d  = row_q + ROW_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        col_d  = col_q + COL_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    busy_d = (count_d != '0) || (col_d != '0) || (row_d != '0);
  end

  // IDLE/FRAME_END look at the registered count, so a freshly pushed pixel
  // is presented one cycle after it is captured.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = WRITE;
      end
      WRITE: begin
        if (pop && last_col && last_row) begin
          state_d = FRAME_END;
        end else if (pop && !push && (count_q == CNT_W'(1))) begin
          state_d = IDLE;
        end
      end
      FRAME_END: begin
        state_d = (count_q != '0) ? WRITE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.pixIn;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (bus.done && !push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign bus.wrEn      = (state_q == WRITE);
  assign bus.wrAddr    = addr_q;
  assign bus.wrData    = mem_q[rd_ptr_q];
  assign bus.frameDone = (state_q == FRAME_END);
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_median_result_writer.sv
// tb/tb_median_result_writer.sv - self-checking bench for median_result_writer on a 4x3 frame
module tb_median_result_writer;
  localparam int LEN  = 4;
  localparam int WID  = 3;
  localparam int DW   = 8;
  localparam int DEP  = 4;
  localparam int AW   = 4;
  localparam int NPIX = LEN * WID;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  median_result_writer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  median_result_writer #(
    .LENGTH(LEN), .WIDTH(WID), .DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending pixels as a queue, frame position as a plain
  // pixel index, write request derived from what was pending before each edge.
  int unsigned m_q[$];
  int          m_pos;
  bit          m_wren, m_fdone, m_ovf, m_busy;

  always @(posedge clk or posedge rst) begin
    int prior;
    bit xfer, acc, last, was_writing;
    if (rst) begin
      m_q.delete();
      m_pos   = 0;
      m_wren  = 0;
      m_fdone = 0;
      m_ovf   = 0;
      m_busy  = 0;
    end else begin
      prior       = m_q.size();
      was_writing = m_wren;
      xfer        = m_wren && bus.wrReady;
      acc         = bus.done && ((prior < DEP) || xfer);
      last        = 0;
      if (xfer) begin
        void'(m_q.pop_front());
        last  = (m_pos == NPIX - 1);
        m_pos = last ? 0 : m_pos + 1;
      end
      if (acc) m_q.push_back(int'(bus.pixIn));
      else if (bus.done) m_ovf = 1;
      m_fdone = last;
      if (last) m_wren = 0;
      else if (was_writing) m_wren = (m_q.size() != 0);
      else m_wren = (prior != 0);
      m_busy = (m_q.size() != 0) || (m_pos != 0);
    end
  end

  int log_addr[$];
  int log_data[$];
  int log_cyc[$];
  int fd_count;
  int fd_cyc;

  always @(negedge clk) begin
    #3;
    if (!rst) begin
      check("wrEn", 32'(bus.wrEn), 32'(m_wren));
      check("frameDone", 32'(bus.frameDone), 32'(m_fdone));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("busy", 32'(bus.busy), 32'(m_busy));
      if (m_wren) begin
        check("wrAddr", 32'(bus.wrAddr), 32'(m_pos));
        check("wrData", 32'(bus.wrData), 32'(m_q[0]));
      end
      if (bus.wrEn && bus.wrReady) begin
        log_addr.push_back(int'(bus.wrAddr));
        log_data.push_back(int'(bus.wrData));
        log_cyc.push_back(cyc);
      end
      if (bus.frameDone) begin
        fd_count++;
        fd_cyc = cyc;
      end
    end
  end

  task automatic drive(input bit d, input int p, input bit r);
    @(negedge clk);
    bus.done    = d;
    bus.pixIn   = DW'(p);
    bus.wrReady = r;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
    fd_count = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.done    = 1'b0;
    bus.wrReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  task automatic settle();
    @(negedge clk);
    #4;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dn_pct, rd_pct;
    n_cmp       = 0;
    n_bad       = 0;
    cyc         = 0;
    fd_count    = 0;
    fd_cyc      = 0;
    rst         = 1'b1;
    bus.done    = 1'b0;
    bus.pixIn   = '0;
    bus.wrReady = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_wrEn", 32'(bus.wrEn), 0);
    check("rst_wrAddr", 32'(bus.wrAddr), 0);
    check("rst_wrData", 32'(bus.wrData), 0);
    check("rst_frameDone", 32'(bus.frameDone), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_busy", 32'(bus.busy), 0);

    // Single pixel latency
    drive(1, 8'hA5, 1);
    drive(0, 0, 1);
    settle();
    check("lat_wrEn", 32'(bus.wrEn), 1);
    check("lat_wrAddr", 32'(bus.wrAddr), 0);
    check("lat_wrData", 32'(bus.wrData), 32'hA5);
    settle();
    check("lat_wrEn_after", 32'(bus.wrEn), 0);
    check("lat_busy_after", 32'(bus.busy), 1);

    // Backpressure and overflow
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, i, 0);
    drive(1, 5, 0);
    drive(0, 0, 0);
    #4;
    check("bp_overflow", 32'(bus.overflow), 1);
    check("bp_wrEn", 32'(bus.wrEn), 1);
    check("bp_wrAddr", 32'(bus.wrAddr), 0);
    check("bp_wrData", 32'(bus.wrData), 1);
    drive(0, 0, 1);
    repeat (8) @(negedge clk);
    check("bp_nwrites", log_addr.size(), 4);
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check("bp_addr", log_addr[i], i);
      check("bp_data", log_data[i], i + 1);
    end

    // Full FIFO with simultaneous push and pop, then row wrap at the 5th pixel
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1, i, 0);
    drive(1, 9, 1);
    drive(0, 0, 0);
    #4;
    check("full_overflow", 32'(bus.overflow), 0);
    check("full_model_count", m_q.size(), 4);
    check("full_wrAddr", 32'(bus.wrAddr), 1);
    check("full_wrData", 32'(bus.wrData), 2);
    drive(0, 0, 1);
    repeat (8) @(negedge clk);
    check("wrap_nwrites", log_addr.size(), 5);
    for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
      check("wrap_addr", log_addr[i], i);
      check("wrap_data", log_data[i], (i < 4) ? i + 1 : 9);
    end
    check("wrap_busy", 32'(bus.busy), 1);

    // Whole frame plus one pixel
    do_reset();
    for (int k = 0; k < 13; k++) drive(1, k + 16, 1);
    drive(0, 0, 1);
    repeat (8) @(negedge clk);
    check("fe_nwrites", log_addr.size(), 13);
    if (log_addr.size() == 13) begin
      for (int k = 0; k < 13; k++) begin
        check("fe_addr", log_addr[k], k % NPIX);
        check("fe_data", log_data[k], k + 16);
      end
      for (int k = 1; k < 12; k++) check("fe_gap", log_cyc[k] - log_cyc[k-1], 1);
      check("fe_bubble", log_cyc[12] - log_cyc[11], 2);
      check("fe_pulse_cycle", fd_cyc, log_cyc[11] + 1);
    end
    check("fe_pulses", fd_count, 1);
    check("fe_busy", 32'(bus.busy), 1);

    // Reset in the middle of a stalled handshake
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, i + 40, 0);
    drive(0, 0, 0);
    #4;
    check("mid_wrEn_before", 32'(bus.wrEn), 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_wrEn", 32'(bus.wrEn), 0);
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_model_count", m_q.size(), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    drive(1, 77, 1);
    drive(0, 0, 1);
    repeat (4) @(negedge clk);
    check("mid_nwrites", log_addr.size(), 1);
    if (log_addr.size() == 1) begin
      check("mid_addr", log_addr[0], 0);
      check("mid_data", log_data[0], 77);
    end

    // Randomized traffic with varying load and backpressure
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      dn_pct = 30 + 12 * blk;
      rd_pct = 95 - 13 * blk;
      repeat (500) begin
        drive($urandom_range(0, 99) < dn_pct, $urandom_range(0, 255),
              $urandom_range(0, 99) < rd_pct);
      end
    end
    drive(0, 0, 1);
    repeat (20) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
